// File: rtl/alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// alu_rr_scheduler : round-robin front end sharing one combinational ALU
// Revision 1.0
// ============================================================================
module alu_rr_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   parameter int SHW     = 5,
   parameter int IDW     = 2,
   parameter int NUM_OPS = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*4-1:0]   req_opcode,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   input  logic [NUM_REQ*SHW-1:0] req_shift,
   output logic [3:0]             alu_opcode,
   output logic [WIDTH-1:0]       alu_input1,
   output logic [WIDTH-1:0]       alu_input2,
   output logic [SHW-1:0]         alu_shift,
   input  logic [WIDTH-1:0]       alu_result,
   input  logic                   alu_carry,
   input  logic                   alu_zero,
   input  logic                   alu_sign,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [IDW-1:0]         rsp_id,
   output logic [WIDTH-1:0]       rsp_result,
   output logic                   rsp_carry,
   output logic                   rsp_zero,
   output logic                   rsp_sign,
   output logic                   rsp_err,
   output logic                   busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDW-1:0]   r_last_grant;
   logic [IDW-1:0]   w_grant;
   logic             w_found;
   logic [3:0]       w_sel_op;
   logic             w_illegal;

   // First valid requester after the previous winner, wrapping modulo NUM_REQ
   always_comb begin
      int idx;
      w_grant = '0;
      w_found = 1'b0;
      idx     = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(r_last_grant) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!w_found && req_valid[IDW'(idx)]) begin
            w_found = 1'b1;
            w_grant = IDW'(idx);
         end
      end
   end

   assign w_sel_op  = req_opcode[int'(w_grant)*4 +: 4];
   assign w_illegal = int'(w_sel_op) >= NUM_OPS;

   // Accept is offered only in IDLE and never looks at rsp_ready
   always_comb begin
      req_ready = '0;
      if (r_state == S_IDLE && w_found) req_ready[w_grant] = 1'b1;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_found) w_state_nxt = w_illegal ? S_RESP : S_EXEC;
         S_EXEC:  w_state_nxt = S_RESP;
         S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_last_grant <= IDW'(NUM_REQ - 1);
         alu_opcode   <= '0;
         alu_input1   <= '0;
         alu_input2   <= '0;
         alu_shift    <= '0;
         rsp_id       <= '0;
         rsp_result   <= '0;
         rsp_carry    <= 1'b0;
         rsp_zero     <= 1'b0;
         rsp_sign     <= 1'b0;
         rsp_err      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  alu_opcode   <= w_sel_op;
                  alu_input1   <= req_a[int'(w_grant)*WIDTH +: WIDTH];
                  alu_input2   <= req_b[int'(w_grant)*WIDTH +: WIDTH];
                  alu_shift    <= req_shift[int'(w_grant)*SHW +: SHW];
                  rsp_id       <= w_grant;
                  r_last_grant <= w_grant;
                  // Illegal ops bypass the ALU and report straight away
                  if (w_illegal) begin
                     rsp_result <= '0;
                     rsp_carry  <= 1'b0;
                     rsp_zero   <= 1'b0;
                     rsp_sign   <= 1'b0;
                     rsp_err    <= 1'b1;
                  end
               end
            end
            S_EXEC: begin
               rsp_result <= alu_result;
               rsp_carry  <= alu_carry;
               rsp_zero   <= alu_zero;
               rsp_sign   <= alu_sign;
               rsp_err    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign rsp_valid = (r_state == S_RESP);
   assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
